// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache line store: access size encodings
// and the helper functions that derive field widths and access lengths.
package cache_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   // Reserved size reports zero bytes so it can never enable a write lane.
   function automatic int unsigned size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return 1;
         SZ_HALF: return 2;
         SZ_WORD: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic int off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

endpackage

// File: rtl/cache_bank.sv
// One bank of the line store: a single-port array of whole lines with
// per-byte write enables and a registered (read-before-write) read.
module cache_bank #(
   parameter int LINE_BYTES = 64,
   parameter int ROW_W      = 4
) (
   input  logic                    clk,
   input  logic                    i_we,
   input  logic [ROW_W-1:0]        i_row,
   input  logic [LINE_BYTES-1:0]   i_be,
   input  logic [LINE_BYTES*8-1:0] i_wdata,
   output logic [LINE_BYTES*8-1:0] o_rdata
);

   logic [LINE_BYTES*8-1:0] r_mem [1 << ROW_W];
   logic [LINE_BYTES*8-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (i_be[b]) begin
               r_mem[i_row][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
      r_rdata <= r_mem[i_row];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_line_store.sv
// Banked L1 data array: single-cycle byte/half/word CPU access at any
// alignment (including line straddles), plus full-line refill and eviction.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int LINE_BYTES = 64,
   parameter int NUM_LINES  = 32,
   parameter int ADDR_W     = 13
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [1:0]                    req_size,
   input  logic                          req_signed,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [31:0]                   req_wdata,
   output logic                          rsp_valid,
   output logic [31:0]                   rsp_rdata,
   output logic                          rsp_err,
   input  logic                          line_wr,
   input  logic [idx_w(NUM_LINES)-1:0]   line_idx,
   input  logic [LINE_BYTES*8-1:0]       line_wdata,
   input  logic                          evict_req,
   output logic                          evict_valid,
   output logic [LINE_BYTES*8-1:0]       evict_data
);

   localparam int OFF_W  = off_w(LINE_BYTES);
   localparam int IDX_W  = idx_w(NUM_LINES);
   localparam int ROW_W  = (IDX_W > 1) ? IDX_W - 1 : 1;
   localparam int LINE_W = LINE_BYTES * 8;

   logic [OFF_W-1:0]        w_off;
   logic [IDX_W-1:0]        w_idx;
   logic [IDX_W-1:0]        w_idxNext;
   logic                    w_accept;
   logic                    w_store;
   logic [3:0]              w_sizeMask;
   logic [2*LINE_BYTES-1:0] w_be2;
   logic [2*LINE_W-1:0]     w_wd2;

   logic                    w_weEven, w_weOdd;
   logic [ROW_W-1:0]        w_rowEven, w_rowOdd;
   logic [LINE_BYTES-1:0]   w_beEven, w_beOdd;
   logic [LINE_W-1:0]       w_wdEven, w_wdOdd;
   logic [LINE_W-1:0]       w_rdEven, w_rdOdd;

   logic                    r_rspValid, r_rspErr, r_rspLoad, r_rspOdd, r_rspSigned;
   logic [OFF_W-1:0]        r_rspOff;
   size_e                   r_rspSize;
   logic                    r_evictValid, r_evictOdd;

   logic [LINE_W-1:0]       w_rdLo, w_rdHi;
   logic [2*LINE_W-1:0]     w_rd2;
   logic [31:0]             w_raw, w_ext;
   logic                    w_unusedBits;

   assign w_off      = req_addr[OFF_W-1:0];
   assign w_idx      = req_addr[OFF_W +: IDX_W];
   assign w_idxNext  = w_idx + 1'b1;
   assign req_ready  = !line_wr && !evict_req;
   assign w_accept   = req_valid && req_ready;
   assign w_store    = w_accept && req_write && (req_size != SZ_RSVD) && rst_n;
   assign w_sizeMask = 4'((32'd1 << size_bytes(req_size)) - 32'd1);

   // Place the access in a two-line window: low half is line IDX, high half IDX+1.
   assign w_be2 = {{(2*LINE_BYTES-4){1'b0}}, w_sizeMask} << w_off;
   assign w_wd2 = {{(2*LINE_W-32){1'b0}}, req_wdata} << {w_off, 3'b000};

   always_comb begin
      w_weEven  = 1'b0;
      w_weOdd   = 1'b0;
      w_rowEven = ROW_W'(line_idx >> 1);
      w_rowOdd  = ROW_W'(line_idx >> 1);
      w_beEven  = '1;
      w_beOdd   = '1;
      w_wdEven  = line_wdata;
      w_wdOdd   = line_wdata;
      if (line_wr) begin
         w_weEven = rst_n && !line_idx[0];
         w_weOdd  = rst_n && line_idx[0];
      end else if (!evict_req) begin
         w_weEven = w_store;
         w_weOdd  = w_store;
         if (!w_idx[0]) begin
            w_rowEven = ROW_W'(w_idx >> 1);
            w_rowOdd  = ROW_W'(w_idxNext >> 1);
            w_beEven  = w_be2[LINE_BYTES-1:0];
            w_beOdd   = w_be2[2*LINE_BYTES-1:LINE_BYTES];
            w_wdEven  = w_wd2[LINE_W-1:0];
            w_wdOdd   = w_wd2[2*LINE_W-1:LINE_W];
         end else begin
            w_rowOdd  = ROW_W'(w_idx >> 1);
            w_rowEven = ROW_W'(w_idxNext >> 1);
            w_beOdd   = w_be2[LINE_BYTES-1:0];
            w_beEven  = w_be2[2*LINE_BYTES-1:LINE_BYTES];
            w_wdOdd   = w_wd2[LINE_W-1:0];
            w_wdEven  = w_wd2[2*LINE_W-1:LINE_W];
         end
      end
   end

   cache_bank #(.LINE_BYTES(LINE_BYTES), .ROW_W(ROW_W)) u_bankEven (
      .clk(clk), .i_we(w_weEven), .i_row(w_rowEven), .i_be(w_beEven),
      .i_wdata(w_wdEven), .o_rdata(w_rdEven)
   );

   cache_bank #(.LINE_BYTES(LINE_BYTES), .ROW_W(ROW_W)) u_bankOdd (
      .clk(clk), .i_we(w_weOdd), .i_row(w_rowOdd), .i_be(w_beOdd),
      .i_wdata(w_wdOdd), .o_rdata(w_rdOdd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspValid   <= 1'b0;
         r_rspErr     <= 1'b0;
         r_rspLoad    <= 1'b0;
         r_rspOdd     <= 1'b0;
         r_rspSigned  <= 1'b0;
         r_rspOff     <= '0;
         r_rspSize    <= SZ_BYTE;
         r_evictValid <= 1'b0;
         r_evictOdd   <= 1'b0;
      end else begin
         r_rspValid   <= w_accept;
         r_rspErr     <= w_accept && (req_size == SZ_RSVD);
         r_rspLoad    <= w_accept && !req_write && (req_size != SZ_RSVD);
         r_evictValid <= evict_req;
         if (w_accept) begin
            r_rspOdd    <= w_idx[0];
            r_rspSigned <= req_signed;
            r_rspOff    <= w_off;
            r_rspSize   <= size_e'(req_size);
         end
         if (evict_req) begin
            r_evictOdd <= line_idx[0];
         end
      end
   end

   // Reassemble the two-line window in address order and pick the access bytes.
   assign w_rdLo = r_rspOdd ? w_rdOdd : w_rdEven;
   assign w_rdHi = r_rspOdd ? w_rdEven : w_rdOdd;
   assign w_rd2  = {w_rdHi, w_rdLo} >> {r_rspOff, 3'b000};
   assign w_raw  = w_rd2[31:0];

   always_comb begin
      w_ext = w_raw;
      case (r_rspSize)
         SZ_BYTE: w_ext = {{24{r_rspSigned & w_raw[7]}}, w_raw[7:0]};
         SZ_HALF: w_ext = {{16{r_rspSigned & w_raw[15]}}, w_raw[15:0]};
         default: w_ext = w_raw;
      endcase
   end

   assign rsp_valid   = r_rspValid;
   assign rsp_err     = r_rspErr;
   assign rsp_rdata   = r_rspLoad ? w_ext : 32'd0;
   assign evict_valid = r_evictValid;
   assign evict_data  = r_evictValid ? (r_evictOdd ? w_rdOdd : w_rdEven) : '0;

   assign w_unusedBits = ^{req_addr, w_rd2};

endmodule
